// File: rtl/ps2_key_tracker_pkg.sv
// Shared constants for the PS/2 direction tracker: set-2 scan codes, receiver
// states, direction-bus bit positions and the key-to-direction lookup.
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;

    localparam int BTN_UP    = 3;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_LEFT  = 0;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Arrows live in the E0-prefixed space, WASD in the plain space.
    function automatic logic [3:0] key_mask(input logic [7:0] code, input logic ext);
        key_mask = '0;
        if (ext) begin
            case (code)
                SC_UP:    key_mask[BTN_UP]    = 1'b1;
                SC_DOWN:  key_mask[BTN_DOWN]  = 1'b1;
                SC_RIGHT: key_mask[BTN_RIGHT] = 1'b1;
                SC_LEFT:  key_mask[BTN_LEFT]  = 1'b1;
                default:  key_mask = '0;
            endcase
        end else begin
            case (code)
                SC_W:    key_mask[BTN_UP]    = 1'b1;
                SC_S:    key_mask[BTN_DOWN]  = 1'b1;
                SC_D:    key_mask[BTN_RIGHT] = 1'b1;
                SC_A:    key_mask[BTN_LEFT]  = 1'b1;
                default: key_mask = '0;
            endcase
        end
    endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// Keyboard-side lines and the decoded direction/debug outputs of the tracker.
interface ps2_key_tracker_if;
    logic       PS2_CLK;
    logic       PS2_DATA;
    logic [3:0] uBtns;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;

    modport master (output PS2_CLK, PS2_DATA, input uBtns, scan_code, scan_valid, frame_err);
    modport slave  (input PS2_CLK, PS2_DATA, output uBtns, scan_code, scan_valid, frame_err);
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 byte receiver: line synchronizers, clock deglitch filter, 11-bit frame
// FSM with odd-parity/stop checks and an inter-strobe timeout.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]  clk_sync, data_sync;
    logic [FW-1:0] fcnt_q;
    logic        filt_q, filt_d1_q;
    logic        strobe, data;

    rx_state_t   state_q, state_d;
    logic [7:0]  shift_q, shift_d, byte_q, byte_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic        par_ok_q, par_ok_d;
    logic        valid_q, valid_d, err_q, err_d;
    logic [TW-1:0] tcnt_q, tcnt_d;

    // NOTE: synchronizers and filter reset to the idle-high line level so that
    // leaving reset never fabricates a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            fcnt_q    <= '0;
            filt_q    <= 1'b1;
            filt_d1_q <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            filt_d1_q <= filt_q;
            if (clk_sync[1] == filt_q) begin
                fcnt_q <= '0;
            end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_q <= clk_sync[1];
                fcnt_q <= '0;
            end else begin
                fcnt_q <= fcnt_q + FW'(1);
            end
        end
    end

    assign strobe = filt_d1_q & ~filt_q;
    assign data   = data_sync[1];

    // NOTE: every comb output takes its default first so no path leaves a
    // variable unassigned (which would infer a latch).
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        par_ok_d = par_ok_q;
        byte_d   = byte_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;

        // tcnt holds the number of cycles elapsed since the last strobe.
        if (state_q == RX_IDLE) tcnt_d = '0;
        else if (strobe)        tcnt_d = TW'(1);
        else                    tcnt_d = tcnt_q + TW'(1);

        case (state_q)
            RX_IDLE: if (strobe && !data) begin
                state_d  = RX_DATA;
                bitcnt_d = '0;
            end
            RX_DATA: if (strobe) begin
                shift_d  = {data, shift_q[7:1]};
                bitcnt_d = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) state_d = RX_PARITY;
            end
            RX_PARITY: if (strobe) begin
                par_ok_d = ^{shift_q, data};
                state_d  = RX_STOP;
            end
            RX_STOP: if (strobe) begin
                if (data && par_ok_q) begin
                    valid_d = 1'b1;
                    byte_d  = shift_q;
                end else begin
                    err_d = 1'b1;
                end
                state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase

        if (state_q != RX_IDLE && !strobe && tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = RX_IDLE;
            err_d   = 1'b1;
            tcnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RX_IDLE;
            shift_q  <= '0;
            bitcnt_q <= '0;
            par_ok_q <= 1'b0;
            byte_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            par_ok_q <= par_ok_d;
            byte_q   <= byte_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            tcnt_q   <= tcnt_d;
        end
    end

    assign rx_byte    = byte_q;
    assign byte_valid = valid_q;
    assign err        = err_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// Tracks held arrow/WASD keys from PS/2 set-2 make/break sequences and drives
// the 4-bit direction bus; raw bytes and framing errors are passed through.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input logic               clk,
    input logic               rst,
    ps2_key_tracker_if.slave  bus
);
    logic [7:0] rx_byte;
    logic       rx_valid, rx_err;
    logic       ext_q, ext_d, brk_q, brk_d;
    logic [3:0] arrow_q, arrow_d, wasd_q, wasd_d, ubtns_q, mask;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (bus.PS2_CLK),
        .ps2_data   (bus.PS2_DATA),
        .rx_byte    (rx_byte),
        .byte_valid (rx_valid),
        .err        (rx_err)
    );

    always_comb begin
        ext_d   = ext_q;
        brk_d   = brk_q;
        arrow_d = arrow_q;
        wasd_d  = wasd_q;
        mask    = key_mask(rx_byte, ext_q);
        if (rx_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (rx_valid) begin
            if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == SC_BRK) begin
                brk_d = 1'b1;
            end else begin
                if (ext_q) arrow_d = brk_q ? (arrow_q & ~mask) : (arrow_q | mask);
                else       wasd_d  = brk_q ? (wasd_q & ~mask)  : (wasd_q | mask);
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    // Direction bus is registered from the next-state flags so it lands one
    // cycle after scan_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            arrow_q <= '0;
            wasd_q  <= '0;
            ubtns_q <= '0;
        end else begin
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            arrow_q <= arrow_d;
            wasd_q  <= wasd_d;
            ubtns_q <= arrow_d | wasd_d;
        end
    end

    assign bus.uBtns      = ubtns_q;
    assign bus.scan_code  = rx_byte;
    assign bus.scan_valid = rx_valid;
    assign bus.frame_err  = rx_err;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: scripted scenarios plus randomized
// byte streams compared against a held-key table model.
module tb_ps2_key_tracker;
    localparam int FL = 8;
    localparam int TO = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_key_tracker_if bus ();

    ps2_key_tracker #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Monitor, sampled on the falling edge.
    int         cyc = 0;
    int         sv_count = 0, err_count = 0;
    int         sv_cycle = 0, err_cycle = 0, last_fall = 0;
    logic [7:0] last_code = '0;
    logic [3:0] ub_at_sv = '0, ub_next = '0;
    logic       sv_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sv_prev) ub_next = bus.uBtns;
        sv_prev = bus.scan_valid;
        if (bus.scan_valid) begin
            sv_count++;
            sv_cycle  = cyc;
            last_code = bus.scan_code;
            ub_at_sv  = bus.uBtns;
        end
        if (bus.frame_err) begin
            err_count++;
            err_cycle = cyc;
        end
    end

    // Reference model: one held bit per (prefix space, code).
    bit held_ext[256];
    bit held_std[256];
    bit m_ext, m_brk;

    function automatic void model_reset();
        for (int i = 0; i < 256; i++) begin
            held_ext[i] = 1'b0;
            held_std[i] = 1'b0;
        end
        m_ext = 1'b0;
        m_brk = 1'b0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (b == 8'hE0)      m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            if (m_ext) held_ext[b] = !m_brk;
            else       held_std[b] = !m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    function automatic void model_err();
        m_ext = 1'b0;
        m_brk = 1'b0;
    endfunction

    function automatic logic [3:0] model_ub();
        return {held_ext[8'h75] | held_std[8'h1D],
                held_ext[8'h72] | held_std[8'h1B],
                held_ext[8'h74] | held_std[8'h23],
                held_ext[8'h6B] | held_std[8'h1C]};
    endfunction

    // Keyboard driver: data settles while the clock is high, ~20-cycle phases.
    task automatic drive_bit(input logic b);
        @(negedge clk);
        bus.PS2_DATA = b;
        repeat (10) @(negedge clk);
        bus.PS2_CLK = 1'b0;
        last_fall = cyc;
        repeat (20) @(negedge clk);
        bus.PS2_CLK = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_good, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(par_good ? ~^b : ^b);
        drive_bit(stop);
        bus.PS2_DATA = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int sv0;
        logic [3:0] ub0;
        sv0 = sv_count;
        ub0 = bus.uBtns;
        model_byte(b);
        send_frame(b, 1'b1, 1'b1);
        checks++;
        if (sv_count !== sv0 + 1) begin
            errors++; $display("FAIL sv_pulse byte %h: got %0d pulses expected 1", b, sv_count - sv0);
        end
        checks++;
        if (last_code !== b) begin
            errors++; $display("FAIL scan_code: got %h expected %h", last_code, b);
        end
        checks++;
        if (sv_cycle - last_fall != FL + 3) begin
            errors++; $display("FAIL sv_latency byte %h: got %0d expected %0d", b, sv_cycle - last_fall, FL + 3);
        end
        checks++;
        if (ub_at_sv !== ub0) begin
            errors++; $display("FAIL ub_early byte %h: got %b expected %b", b, ub_at_sv, ub0);
        end
        checks++;
        if (ub_next !== model_ub()) begin
            errors++; $display("FAIL uBtns byte %h: got %b expected %b", b, ub_next, model_ub());
        end
    endtask

    task automatic send_bad(input logic par_good, input logic stop);
        int sv0, e0;
        logic [3:0] ub0;
        sv0 = sv_count;
        e0  = err_count;
        ub0 = bus.uBtns;
        model_err();
        send_frame(8'h1D, par_good, stop);
        checks++;
        if (err_count !== e0 + 1) begin
            errors++; $display("FAIL frame_err pulses: got %0d expected 1", err_count - e0);
        end
        checks++;
        if (err_cycle - last_fall != FL + 3) begin
            errors++; $display("FAIL err_latency: got %0d expected %0d", err_cycle - last_fall, FL + 3);
        end
        checks++;
        if (sv_count !== sv0 || bus.uBtns !== ub0) begin
            errors++; $display("FAIL bad_frame_quiet: sv %0d ub %b expected sv 0 ub %b", sv_count - sv0, bus.uBtns, ub0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_ub(input string name, input logic [3:0] exp);
        checks++;
        if (bus.uBtns !== exp) begin
            errors++; $display("FAIL %s: got %b expected %b", name, bus.uBtns, exp);
        end
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        checks++;
        if (bus.uBtns !== 4'b0 || bus.scan_code !== 8'h00 || bus.scan_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got ub=%b code=%h sv=%b err=%b expected all zero",
                     bus.uBtns, bus.scan_code, bus.scan_valid, bus.frame_err);
        end
        rst = 1'b0;
        model_reset();
        repeat (20) @(negedge clk);
    endtask

    task automatic test_arrow();
        int sv0;
        do_reset();
        sv0 = sv_count;
        send_byte(8'hE0); send_byte(8'h75);
        check_ub("arrow_make", 4'b1000);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        check_ub("arrow_break", 4'b0000);
        checks++;
        if (sv_count - sv0 != 5) begin
            errors++; $display("FAIL arrow_sv_count: got %0d expected 5", sv_count - sv0);
        end
    endtask

    task automatic test_or_sources();
        do_reset();
        send_byte(8'h1D);
        send_byte(8'hE0); send_byte(8'h75);
        check_ub("or_both", 4'b1000);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        check_ub("or_w_only", 4'b1000);
        send_byte(8'hF0); send_byte(8'h1D);
        check_ub("or_none", 4'b0000);
        send_byte(8'h1C); send_byte(8'h23);
        check_ub("left_right", 4'b0011);
        send_byte(8'h1C);
        check_ub("typematic", 4'b0011);
    endtask

    task automatic test_parity_error();
        do_reset();
        send_bad(1'b0, 1'b1);
        check_ub("parity_ub", 4'b0000);
        send_byte(8'h1D);
        check_ub("after_parity", 4'b1000);
        send_byte(8'hE0);
        send_bad(1'b1, 1'b0);
        send_byte(8'h6B);
        check_ub("stop_err_clears_ext", 4'b1000);
    endtask

    task automatic test_timeout();
        int e0, sv0;
        do_reset();
        e0  = err_count;
        sv0 = sv_count;
        drive_bit(1'b0);
        drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b0);
        repeat (TO + FL + 40) @(negedge clk);
        checks++;
        if (err_count !== e0 + 1) begin
            errors++; $display("FAIL timeout_pulses: got %0d expected 1", err_count - e0);
        end
        checks++;
        if (err_cycle - last_fall != FL + 2 + TO) begin
            errors++; $display("FAIL timeout_latency: got %0d expected %0d", err_cycle - last_fall, FL + 2 + TO);
        end
        checks++;
        if (sv_count !== sv0) begin
            errors++; $display("FAIL timeout_sv: got %0d expected 0", sv_count - sv0);
        end
        model_err();
        send_byte(8'h23);
        check_ub("after_timeout", 4'b0010);
    endtask

    task automatic test_glitch();
        int sv0, e0;
        logic [7:0] code0;
        logic [3:0] ub0;
        sv0 = sv_count; e0 = err_count; code0 = bus.scan_code; ub0 = bus.uBtns;
        @(negedge clk);
        bus.PS2_CLK = 1'b0;
        repeat (3) @(negedge clk);
        bus.PS2_CLK = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (sv_count !== sv0 || err_count !== e0 || bus.scan_code !== code0 || bus.uBtns !== ub0) begin
            errors++;
            $display("FAIL glitch_quiet: sv %0d err %0d code %h ub %b expected 0 0 %h %b",
                     sv_count - sv0, err_count - e0, bus.scan_code, bus.uBtns, code0, ub0);
        end
        send_byte(8'h1B);
        check_ub("after_glitch", 4'b0110);
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_byte(8'hE0);
        do_reset();
        checks++;
        if (bus.scan_code !== 8'h00) begin
            errors++; $display("FAIL reset_code: got %h expected 00", bus.scan_code);
        end
        send_byte(8'h75);
        check_ub("reset_mid", 4'b0000);
    endtask

    task automatic test_random();
        logic [7:0] pool [15];
        pool = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1D, 8'h1B,
                 8'h1C, 8'h23, 8'hFA, 8'hAA, 8'hE1, 8'h70, 8'hE0};
        do_reset();
        for (int i = 0; i < 45; i++) begin
            if ($urandom_range(0, 9) == 0) send_bad($urandom_range(0, 1) == 1, 1'b0);
            else send_byte(pool[$urandom_range(0, 14)]);
        end
    endtask

    initial begin
        bus.PS2_CLK  = 1'b1;
        bus.PS2_DATA = 1'b1;
        test_reset();
        test_arrow();
        test_or_sources();
        test_parity_error();
        test_timeout();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
